// File: rtl/insn_fetch_align.sv
// ---------------------------------------------------------------------------
// insn_fetch_align
//
// Instruction-fetch front end ahead of the compressed-instruction expansion
// stage. It issues word-aligned reads and rebuilds a 16-bit-aligned (RVC)
// instruction stream into whole raw instructions. A 16-bit carry buffer keeps
// the upper half of the last fetched word, so that a compressed instruction
// or the low half of a straddling 32-bit instruction can be used without
// another read.
//
// Parameters
//   PROGADDR_RESET   PC loaded at reset.
//   COMPRESSED_ISA   1: 16-bit alignment and carry buffer enabled.
//                    0: every word is one 32-bit instruction, pc[1:0] = 0.
//
// Optional feature (macro FETCH_MISALIGN_EN)
//   Adds output insn_misalign. A redirect to a misaligned PC (bit0 set, or
//   bit1 set without COMPRESSED_ISA) produces one insn_valid beat with
//   insn_misalign=1 and no memory access. After it is accepted the block
//   sits in HALT until the next redirect. Without the macro the low PC bits
//   are silently cleared.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   redirect_valid/_pc  one-cycle pulse loading a new PC (highest priority)
//   mem_valid/mem_addr  read request, word address, held until mem_ready
//   mem_ready/mem_rdata read completion and data
//   insn_valid/insn_ready  instruction output handshake
//   insn_data         raw instruction ([31:16]=0 when compressed)
//   insn_pc           address of insn_data
//   insn_compressed   insn_data[1:0] != 2'b11
//
// Handshake rule (both interfaces): a transfer happens on a rising clk edge
// where valid && ready. While valid is high and ready is low the producer
// keeps valid and every payload signal unchanged. mem_valid is never
// withdrawn before mem_ready, not even on redirect.
// ---------------------------------------------------------------------------
module insn_fetch_align #(
    parameter logic [31:0] PROGADDR_RESET = 32'h0000_0000,
    parameter bit          COMPRESSED_ISA = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        insn_valid,
    input  logic        insn_ready,
    output logic [31:0] insn_data,
    output logic [31:0] insn_pc,
`ifdef FETCH_MISALIGN_EN
    output logic        insn_misalign,
`endif
    output logic        insn_compressed
);

    // FETCH    : word request outstanding (or about to be issued after reset)
    // FETCH_HI : upper word of a straddling 32-bit instruction outstanding
    // OUT      : instruction presented, waiting for insn_ready
    // HALT     : stopped after a misaligned redirect was delivered
    typedef enum logic [1:0] {
        ST_FETCH    = 2'd0,
        ST_FETCH_HI = 2'd1,
        ST_OUT      = 2'd2,
        ST_HALT     = 2'd3
    } state_e;

    localparam logic [31:0] PC_RESET = COMPRESSED_ISA ? {PROGADDR_RESET[31:1], 1'b0}
                                                      : {PROGADDR_RESET[31:2], 2'b00};

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [15:0] buf_q, buf_d;
    logic [31:0] buf_addr_q, buf_addr_d;
    logic        buf_valid_q, buf_valid_d;
    // Set while the outstanding read belongs to a PC that was redirected away.
    logic        discard_q, discard_d;
    logic        mem_valid_q, mem_valid_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        insn_valid_q, insn_valid_d;
    logic [31:0] insn_data_q, insn_data_d;
    logic [31:0] insn_pc_q, insn_pc_d;
    logic        insn_comp_q, insn_comp_d;
`ifdef FETCH_MISALIGN_EN
    logic        misalign_q, misalign_d;
    // Misaligned redirect waiting for an outstanding read to drain.
    logic        mis_pend_q, mis_pend_d;
    logic        redir_bad;
`endif

    logic [31:0] redir_pc_fixed;
    logic [31:0] pc_inc;
    logic        accept;
    logic        do_launch;
    logic [31:0] launch_pc;
    logic        launch_buf_ok;
    logic        buf_hit;

    assign redir_pc_fixed = COMPRESSED_ISA ? {redirect_pc[31:1], 1'b0}
                                           : {redirect_pc[31:2], 2'b00};
`ifdef FETCH_MISALIGN_EN
    assign redir_bad = redirect_pc[0] | (!COMPRESSED_ISA & redirect_pc[1]);
`endif
    assign pc_inc = insn_comp_q ? 32'd2 : 32'd4;
    assign accept = insn_valid_q & insn_ready;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        buf_d         = buf_q;
        buf_addr_d    = buf_addr_q;
        buf_valid_d   = buf_valid_q;
        discard_d     = discard_q;
        mem_valid_d   = mem_valid_q;
        mem_addr_d    = mem_addr_q;
        insn_valid_d  = insn_valid_q;
        insn_data_d   = insn_data_q;
        insn_pc_d     = insn_pc_q;
        insn_comp_d   = insn_comp_q;
`ifdef FETCH_MISALIGN_EN
        misalign_d    = misalign_q;
        mis_pend_d    = mis_pend_q;
`endif
        // "Launch" starts work on launch_pc: either serve it from the carry
        // buffer or issue the read it needs. It is shared by reset exit,
        // accept, redirect and the end of a discarded read.
        do_launch     = 1'b0;
        launch_pc     = pc_q;
        launch_buf_ok = buf_valid_q;
        buf_hit       = 1'b0;

        if (redirect_valid) begin
            buf_valid_d  = 1'b0;
            insn_valid_d = 1'b0;
`ifdef FETCH_MISALIGN_EN
            misalign_d   = 1'b0;
            mis_pend_d   = redir_bad;
            pc_d         = redir_bad ? redirect_pc : redir_pc_fixed;
`else
            pc_d         = redir_pc_fixed;
`endif
            if (mem_valid_q && !mem_ready) begin
                // Read keeps its address until it completes; data then dropped.
                discard_d = 1'b1;
                state_d   = ST_FETCH;
            end else begin
                // No read pending, or it completes now and is dropped.
                discard_d     = 1'b0;
                mem_valid_d   = 1'b0;
                do_launch     = 1'b1;
                launch_pc     = pc_d;
                launch_buf_ok = 1'b0;
            end
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (!mem_valid_q) begin
                        // Only reached straight out of reset.
                        do_launch = 1'b1;
                    end else if (mem_ready) begin
                        mem_valid_d = 1'b0;
                        if (discard_q) begin
                            discard_d     = 1'b0;
                            do_launch     = 1'b1;
                            launch_buf_ok = 1'b0;
                        end else if (!COMPRESSED_ISA || (!pc_q[1] && mem_rdata[1:0] == 2'b11)) begin
                            state_d      = ST_OUT;
                            insn_valid_d = 1'b1;
                            insn_data_d  = mem_rdata;
                            insn_pc_d    = pc_q;
                            insn_comp_d  = 1'b0;
                        end else if (!pc_q[1]) begin
                            // Low half compressed; keep upper half for pc+2.
                            state_d      = ST_OUT;
                            insn_valid_d = 1'b1;
                            insn_data_d  = {16'h0000, mem_rdata[15:0]};
                            insn_pc_d    = pc_q;
                            insn_comp_d  = 1'b1;
                            buf_d        = mem_rdata[31:16];
                            buf_addr_d   = pc_q + 32'd2;
                            buf_valid_d  = 1'b1;
                        end else begin
                            // pc[1]=1 after a buffer miss: only the upper half is ours.
                            buf_d      = mem_rdata[31:16];
                            buf_addr_d = pc_q;
                            if (mem_rdata[17:16] != 2'b11) begin
                                state_d      = ST_OUT;
                                insn_valid_d = 1'b1;
                                insn_data_d  = {16'h0000, mem_rdata[31:16]};
                                insn_pc_d    = pc_q;
                                insn_comp_d  = 1'b1;
                                buf_valid_d  = 1'b0;
                            end else begin
                                state_d     = ST_FETCH_HI;
                                buf_valid_d = 1'b1;
                                mem_valid_d = 1'b1;
                                mem_addr_d  = {pc_q[31:2] + 30'd1, 2'b00};
                            end
                        end
                    end
                end
                ST_FETCH_HI: begin
                    if (mem_ready) begin
                        // buf_q holds the low half; new upper half goes to buffer.
                        state_d      = ST_OUT;
                        mem_valid_d  = 1'b0;
                        insn_valid_d = 1'b1;
                        insn_data_d  = {mem_rdata[15:0], buf_q};
                        insn_pc_d    = pc_q;
                        insn_comp_d  = 1'b0;
                        buf_d        = mem_rdata[31:16];
                        buf_addr_d   = pc_q + 32'd4;
                        buf_valid_d  = 1'b1;
                    end
                end
                ST_OUT: begin
                    if (accept) begin
                        insn_valid_d = 1'b0;
`ifdef FETCH_MISALIGN_EN
                        if (misalign_q) begin
                            misalign_d = 1'b0;
                            state_d    = ST_HALT;
                        end else begin
                            do_launch = 1'b1;
                            launch_pc = pc_q + pc_inc;
                        end
`else
                        do_launch = 1'b1;
                        launch_pc = pc_q + pc_inc;
`endif
                    end
                end
                ST_HALT: begin
                    // Idle until a redirect.
                end
                default: begin
                    state_d = ST_FETCH;
                end
            endcase
        end

        if (do_launch) begin
            pc_d    = launch_pc;
            buf_hit = COMPRESSED_ISA && launch_pc[1] && launch_buf_ok && (buf_addr_q == launch_pc);
`ifdef FETCH_MISALIGN_EN
            if (mis_pend_d) begin
                state_d      = ST_OUT;
                mis_pend_d   = 1'b0;
                misalign_d   = 1'b1;
                mem_valid_d  = 1'b0;
                insn_valid_d = 1'b1;
                insn_data_d  = 32'h0000_0000;
                insn_pc_d    = launch_pc;
                insn_comp_d  = 1'b0;
            end else
`endif
            if (buf_hit && buf_q[1:0] != 2'b11) begin
                // Compressed instruction already in the buffer: no read.
                state_d      = ST_OUT;
                insn_valid_d = 1'b1;
                insn_data_d  = {16'h0000, buf_q};
                insn_pc_d    = launch_pc;
                insn_comp_d  = 1'b1;
                buf_valid_d  = 1'b0;
            end else if (buf_hit) begin
                // Buffer holds the low half of a straddler; fetch the next word.
                state_d     = ST_FETCH_HI;
                mem_valid_d = 1'b1;
                mem_addr_d  = {launch_pc[31:2] + 30'd1, 2'b00};
            end else begin
                state_d     = ST_FETCH;
                mem_valid_d = 1'b1;
                mem_addr_d  = {launch_pc[31:2], 2'b00};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_FETCH;
            pc_q         <= PC_RESET;
            buf_q        <= 16'h0000;
            buf_addr_q   <= 32'h0000_0000;
            buf_valid_q  <= 1'b0;
            discard_q    <= 1'b0;
            mem_valid_q  <= 1'b0;
            mem_addr_q   <= 32'h0000_0000;
            insn_valid_q <= 1'b0;
            insn_data_q  <= 32'h0000_0000;
            insn_pc_q    <= 32'h0000_0000;
            insn_comp_q  <= 1'b0;
`ifdef FETCH_MISALIGN_EN
            misalign_q   <= 1'b0;
            mis_pend_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            buf_q        <= buf_d;
            buf_addr_q   <= buf_addr_d;
            buf_valid_q  <= buf_valid_d;
            discard_q    <= discard_d;
            mem_valid_q  <= mem_valid_d;
            mem_addr_q   <= mem_addr_d;
            insn_valid_q <= insn_valid_d;
            insn_data_q  <= insn_data_d;
            insn_pc_q    <= insn_pc_d;
            insn_comp_q  <= insn_comp_d;
`ifdef FETCH_MISALIGN_EN
            misalign_q   <= misalign_d;
            mis_pend_q   <= mis_pend_d;
`endif
        end
    end

    assign mem_valid       = mem_valid_q;
    assign mem_addr        = mem_addr_q;
    assign insn_valid      = insn_valid_q;
    assign insn_data       = insn_data_q;
    assign insn_pc         = insn_pc_q;
    assign insn_compressed = insn_comp_q;
`ifdef FETCH_MISALIGN_EN
    assign insn_misalign   = misalign_q;
`endif

endmodule
